clock_multiplier: RTL and testbench

CLOCK_MULTIPLIER -- requirements
Module: clock_multiplier

---
 rtl/clock_multiplier.sv | 53 +++++
 tb/tb_clock_multiplier.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/clock_multiplier.sv
// clock_multiplier: phase-accumulator NCO running on clk_in.
// The accumulator advances by PHASE_INC every cycle and its top bit is
// the synthesized clock, so f_out = f_in * PHASE_INC / 2^ACC_WIDTH with
// no long-term drift. Residual phase is kept in the low bits, which is
// what keeps the average frequency exact when the ratio is not integral.
// rst_n is a synchronous, active-HIGH reset despite its name.
module clock_multiplier #(
    parameter int unsigned     ACC_WIDTH = 32,
    parameter longint unsigned PHASE_INC = 64'd42949673
) (
    input  logic clk_in,
    input  logic rst_n,
    output logic clk_out
);

    // Largest legal increment: half a turn, giving f_in/2 output.
    localparam longint unsigned HALF_TURN = 64'd1 << (ACC_WIDTH - 32'd1);

    // Increment truncated to accumulator width; legal values always fit.
    localparam logic [ACC_WIDTH-1:0] INC = ACC_WIDTH'(PHASE_INC);

    // Reject configurations that would otherwise alias silently.
    if ((ACC_WIDTH < 32'd4) || (ACC_WIDTH > 32'd48)) begin : g_bad_width
        $error("clock_multiplier: ACC_WIDTH=%0d outside 4..48", ACC_WIDTH);
    end
    if ((PHASE_INC < 64'd1) || (PHASE_INC > HALF_TURN)) begin : g_bad_inc
        $error("clock_multiplier: PHASE_INC=%0d outside 1..2^(ACC_WIDTH-1)", PHASE_INC);
    end

    logic [ACC_WIDTH-1:0] acc_r;
    logic [ACC_WIDTH-1:0] acc_next_s;

    // Next phase: clear on reset, otherwise add the increment and let
    // the carry fall off the top (modulo-2^ACC_WIDTH wrap).
    always_comb begin
        acc_next_s = {ACC_WIDTH{1'b0}};
        if (rst_n) begin
            acc_next_s = {ACC_WIDTH{1'b0}};
        end else begin
            acc_next_s = acc_r + INC;
        end
    end

    // Phase accumulator register; the only state in the block.
    always_ff @(posedge clk_in) begin
        acc_r <= acc_next_s;
    end

    // Output comes straight from the accumulator MSB flop, so it cannot
    // glitch and carries no combinational logic after the register.
    assign clk_out = acc_r[ACC_WIDTH-1];

endmodule

// File: tb/tb_clock_multiplier.sv
// Directed bench for clock_multiplier: four configurations side by side
// on one 100 MHz clock, with hand-computed expected output sequences.
module tb_clock_multiplier;

    logic clk = 1'b0;
    logic rst = 1'b1;      // shared reset for most instances
    logic rst_mid = 1'b1;  // reset for the instance pulsed mid-run

    logic out_def;   // defaults: 100 MHz -> 1 MHz
    logic out_i1;    // W=4, inc=1
    logic out_i8;    // W=4, inc=8
    logic out_i3;    // W=4, inc=3
    logic out_mid;   // W=4, inc=1, reset pulsed at edge 10

    int n_checks = 0;
    int n_fail   = 0;

    // 100 MHz clock
    always #5 clk = ~clk;

    clock_multiplier dut_def (.clk_in(clk), .rst_n(rst), .clk_out(out_def));
    clock_multiplier #(.ACC_WIDTH(4), .PHASE_INC(64'd1))
        dut_i1 (.clk_in(clk), .rst_n(rst), .clk_out(out_i1));
    clock_multiplier #(.ACC_WIDTH(4), .PHASE_INC(64'd8))
        dut_i8 (.clk_in(clk), .rst_n(rst), .clk_out(out_i8));
    clock_multiplier #(.ACC_WIDTH(4), .PHASE_INC(64'd3))
        dut_i3 (.clk_in(clk), .rst_n(rst), .clk_out(out_i3));
    clock_multiplier #(.ACC_WIDTH(4), .PHASE_INC(64'd1))
        dut_mid (.clk_in(clk), .rst_n(rst_mid), .clk_out(out_mid));

    task automatic check_bit(input string tag, input int k, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s edge %0d: observed %b expected %b", tag, k, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // inc=3 expected clk_out for edges 1..16 (bit i = edge i+1),
        // from acc = 3,6,9,12,15,2,5,8,11,14,1,4,7,10,13,0.
        logic [15:0] exp_i3;
        logic [3:0]  k4;
        logic [3:0]  j4;
        logic        prev_def;
        logic        prev_i3;
        int          rises_def;
        int          rises_i3;
        int          edge_200th;
        exp_i3     = 16'b0110_0011_1001_1100;
        prev_def   = 1'b0;
        prev_i3    = 1'b0;
        rises_def  = 0;
        rises_i3   = 0;
        edge_200th = 0;

        // Reset for three edges; every output must be low.
        rst = 1'b1;
        rst_mid = 1'b1;
        for (int r = 1; r <= 3; r++) begin
            tick();
            check_bit("reset_def", r, out_def, 1'b0);
            check_bit("reset_i1",  r, out_i1,  1'b0);
            check_bit("reset_i8",  r, out_i8,  1'b0);
            check_bit("reset_i3",  r, out_i3,  1'b0);
        end

        // Release; edge k below is the k-th rising edge after release.
        rst = 1'b0;
        rst_mid = 1'b0;
        for (int k = 1; k <= 20000; k++) begin
            tick();
            k4 = 4'(k);
            if (k <= 32) begin
                // inc=1: acc = k mod 16, high for 8..15.
                check_bit("inc1", k, out_i1, k4[3]);
                // inc=8: acc alternates 8,0 -> high on odd edges.
                check_bit("inc8", k, out_i8, k4[0]);
                // Mid-run reset: high edges 8,9; pulse makes edge 10 low,
                // then counting restarts and rises 8 edges later (edge 18).
                if (k < 10) begin
                    check_bit("mid_pre", k, out_mid, k4[3]);
                end else if (k == 10) begin
                    check_bit("mid_rst", k, out_mid, 1'b0);
                end else begin
                    j4 = 4'(k - 10);
                    check_bit("mid_post", k, out_mid, j4[3]);
                end
                if (out_i3 && !prev_i3) rises_i3++;
                prev_i3 = out_i3;
            end
            if (k <= 16) begin
                check_bit("inc3", k, out_i3, exp_i3[k-1]);
            end
            if (k <= 50) begin
                // Defaults: first rise on edge 50.
                check_bit("def_latency", k, out_def, (k >= 50) ? 1'b1 : 1'b0);
            end
            if (out_def && !prev_def) begin
                rises_def++;
                if (rises_def == 200) edge_200th = k;
            end
            prev_def = out_def;
            // Pulse the mid-run reset so it is sampled at edge 10.
            rst_mid = (k == 9) ? 1'b1 : 1'b0;
        end

        // inc=3: exactly 3 rises per 16 cycles.
        check_int("inc3_rises_32", rises_i3, 6);
        // Defaults: 200 rises in 200 us; rise 200 on edge 19950, i.e.
        // exactly 199 periods of 100 cycles after the first rise.
        check_int("def_rises_200us", rises_def, 200);
        check_int("def_rise200_edge", edge_200th, 19950);

        // Reset again mid-operation; latency must repeat identically.
        rst = 1'b1;
        for (int r = 1; r <= 2; r++) begin
            tick();
            check_bit("rereset_def", r, out_def, 1'b0);
            check_bit("rereset_i1",  r, out_i1,  1'b0);
        end
        rst = 1'b0;
        for (int k = 1; k <= 50; k++) begin
            tick();
            k4 = 4'(k);
            if (k <= 16) begin
                check_bit("restart_inc1", k, out_i1, k4[3]);
                check_bit("restart_inc3", k, out_i3, exp_i3[k-1]);
            end
            check_bit("restart_def", k, out_def, (k >= 50) ? 1'b1 : 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
